// File: rtl/fixed_div_16_if.sv
// fixed_div_16_if: start/busy/done handshake and operand/result bus of the Q8.8 divider
//   start    master->slave  request pulse, sampled only while the divider is idle
//   dividend master->slave  numerator, latched on accepted start
//   divisor  master->slave  denominator, latched on accepted start
//   busy     slave->master  high from accept until done
//   done     slave->master  one-cycle result-valid pulse
//   quotient slave->master  result, held until the next result
//   div0     slave->master  divisor was zero
//   ovf      slave->master  true quotient did not fit in WIDTH bits
interface fixed_div_16_if #(parameter int WIDTH = 16);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic             div0;
   logic             ovf;
   modport master (output start, dividend, divisor, input busy, done, quotient, div0, ovf);
   modport slave  (input start, dividend, divisor, output busy, done, quotient, div0, ovf);
endinterface

// File: rtl/fixed_div_16.sv
// fixed_div_16: sequential unsigned Q8.8 restoring divider, one quotient bit per clock
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  fixed_div_16_if slave: start/dividend/divisor in, busy/done/quotient/div0/ovf out
// Optional macro FIXED_DIV_ROUND_EN adds a round-half-up state (one extra cycle).
module fixed_div_16 #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8
) (
   input logic           clk,
   input logic           rst,
   fixed_div_16_if.slave bus
);
   localparam int N  = WIDTH + FRAC;
   localparam int CW = $clog2(N + 1);
`ifdef FIXED_DIV_ROUND_EN
   typedef enum logic [1:0] {IDLE, RUN, RND, FIN} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
`endif
   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
   logic [N-1:0]     num_q, num_d, quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div0_q, div0_d, ovf_q, ovf_d, done_q, done_d;
   logic [WIDTH+1:0] trial;
   // extra top bit acts as the borrow: set means the trial subtraction went negative
   assign trial = {1'b0, rem_q, num_q[N-1]} - {2'b0, dvs_q};
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      num_d   = num_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      div0_d  = div0_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            dvs_d   = bus.divisor;
            rem_d   = '0;
            num_d   = {bus.dividend, {FRAC{1'b0}}};
            quo_d   = '0;
            cnt_d   = '0;
            div0_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            // a failed trial leaves {rem,bit} < divisor, so its top bit is always zero
            rem_d = trial[WIDTH+1] ? {rem_q[WIDTH-2:0], num_q[N-1]} : trial[WIDTH-1:0];
            num_d = num_q << 1;
            quo_d = {quo_q[N-2:0], ~trial[WIDTH+1]};
            cnt_d = cnt_q + 1'b1;
`ifdef FIXED_DIV_ROUND_EN
            if (cnt_q == CW'(N - 1)) state_d = RND;
`else
            if (cnt_q == CW'(N - 1)) state_d = FIN;
`endif
         end
`ifdef FIXED_DIV_ROUND_EN
         RND: begin
            quo_d   = quo_q + N'({rem_q, 1'b0} >= {1'b0, dvs_q});
            state_d = FIN;
         end
`endif
         FIN: begin
            div0_d  = dvs_q == '0;
            ovf_d   = dvs_q != '0 && |quo_q[N-1:WIDTH];
            res_d   = (div0_d || ovf_d) ? '1 : quo_q[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         num_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         num_q   <= num_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         div0_q  <= div0_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end
   assign bus.busy     = state_q != IDLE;
   assign bus.done     = done_q;
   assign bus.quotient = res_q;
   assign bus.div0     = div0_q;
   assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_fixed_div_16.sv
// tb_fixed_div_16: directed self-checking bench for the Q8.8 divider
module tb_fixed_div_16;
`ifdef FIXED_DIV_ROUND_EN
   localparam int          LAT = 26;
   localparam logic [15:0] Q23 = 16'h00AB;
`else
   localparam int          LAT = 25;
   localparam logic [15:0] Q23 = 16'h00AA;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   lat, bcnt, n, m, first, dones;
   always #5 clk = ~clk;
   fixed_div_16_if #(.WIDTH(16)) bus ();
   fixed_div_16 dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic run(input logic [15:0] a, input logic [15:0] b, output int l, output int bc);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      l  = 0;
      bc = 0;
      while (l < 40) begin
         bc += int'(bus.busy);
         if (bus.done) break;
         @(posedge clk);
         #1;
         l++;
      end
   endtask
   initial begin
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_quot", bus.quotient, 0);
      chk("rst_div0", bus.div0, 0);
      chk("rst_ovf", bus.ovf, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      run(16'h0300, 16'h0200, lat, bcnt);
      chk("basic_lat", lat, LAT);
      chk("basic_busy_cycles", bcnt, LAT);
      chk("basic_quot", bus.quotient, 16'h0180);
      chk("basic_div0", bus.div0, 0);
      chk("basic_ovf", bus.ovf, 0);
      chk("basic_busy_at_done", bus.busy, 0);
      @(posedge clk);
      #1;
      chk("basic_done_pulse", bus.done, 0);
      chk("basic_quot_hold", bus.quotient, 16'h0180);
      run(16'h0200, 16'h0300, lat, bcnt);
      chk("two_thirds_lat", lat, LAT);
      chk("two_thirds_quot", bus.quotient, Q23);
      run(16'h0100, 16'h0300, lat, bcnt);
      chk("one_third_quot", bus.quotient, 16'h0055);
      run(16'h1234, 16'h0000, lat, bcnt);
      chk("div0_lat", lat, LAT);
      chk("div0_quot", bus.quotient, 16'hFFFF);
      chk("div0_flag", bus.div0, 1);
      chk("div0_ovf", bus.ovf, 0);
      run(16'h8000, 16'h0040, lat, bcnt);
      chk("ovf_quot", bus.quotient, 16'hFFFF);
      chk("ovf_flag", bus.ovf, 1);
      chk("ovf_div0", bus.div0, 0);
      // start while busy: a second request at edge k+5 must be ignored
      bus.dividend = 16'h0400;
      bus.divisor  = 16'h0200;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n = 0;
      first = -1;
      dones = 0;
      while (n < 40 && first < 0) begin
         @(posedge clk);
         #1;
         n++;
         bus.start = (n == 4);
         if (n == 4) begin
            bus.dividend = 16'h0100;
            bus.divisor  = 16'h0100;
         end
         if (bus.done) begin
            dones++;
            first = n;
         end
      end
      chk("busy_start_lat", first, LAT);
      chk("busy_start_quot", bus.quotient, 16'h0200);
      // back-to-back start on the done cycle
      bus.dividend = 16'h0100;
      bus.divisor  = 16'h0100;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("b2b_accepted_busy", bus.busy, 1);
      chk("b2b_done_low", bus.done, 0);
      m = 0;
      while (m < 40) begin
         if (bus.done) begin
            dones++;
            break;
         end
         @(posedge clk);
         #1;
         m++;
      end
      chk("b2b_lat", m, LAT);
      chk("b2b_quot", bus.quotient, 16'h0100);
      chk("b2b_total_dones", dones, 2);
      // asynchronous reset in the middle of a divide
      bus.dividend = 16'h0300;
      bus.divisor  = 16'h0200;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("pre_rst_busy", bus.busy, 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_busy", bus.busy, 0);
      chk("async_rst_done", bus.done, 0);
      chk("async_rst_quot", bus.quotient, 0);
      chk("async_rst_div0", bus.div0, 0);
      chk("async_rst_ovf", bus.ovf, 0);
      @(negedge clk);
      rst = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         dones += int'(bus.done);
      end
      chk("post_rst_no_done", dones, 0);
      chk("post_rst_idle", bus.busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
